// File: rtl/inert_intf.sv
// inert_intf: inertial front end for the balance controller.
// Waits for IMU power-up, programs the IMU over the shared SPI master,
// then on every IMU data-ready edge reads pitch rate and Y acceleration
// and presents one vld-qualified ptch / ptch_rt sample.
//
// Build option: define INERT_FUSION_EN to build the 27-bit complementary
// fusion accumulator; without it ptch is the raw accelerometer pitch.
//
// state    | meaning
// ---------+--------------------------------------------------
// WAIT_PWR | power-up timer running, no SPI traffic
// INIT1..4 | write one IMU config register each, wait for done
// IDLE     | waiting for a synchronized INT rising edge
// RD_RL    | read pitch-rate low byte
// RD_RH    | read pitch-rate high byte
// RD_AL    | read Y-accel low byte
// RD_AH    | read Y-accel high byte
// CALC     | one-cycle compute slot, vld follows

module inert_intf #(
    parameter int fast_sim = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        vld,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt
);

    typedef enum logic [3:0] {
        WAIT_PWR, INIT1, INIT2, INIT3, INIT4, IDLE,
        RD_RL, RD_RH, RD_AL, RD_AH, CALC
    } state_t;

    localparam logic [15:0] RATE_OFFSET = 16'h0050;

    state_t state, nxt_state;

    logic [15:0] tmr;
    logic        tmr_full;
    logic        int_ff1, int_ff2, int_ff3;
    logic        int_rise;

    logic        wrt_d;
    logic [15:0] cmd_d;
    logic        cap_rl, cap_rh, cap_al, cap_ah, calc;

    logic [7:0]  rate_lo, rate_hi, acc_lo, acc_hi;
    logic [15:0] rt_new;

    logic signed [26:0] acc_ext;
    logic signed [26:0] prod;
    logic signed [15:0] ptch_acc;
    logic               unused_bits;

    assign tmr_full = (fast_sim != 0) ? (&tmr[9:0]) : (&tmr);
    assign int_rise = int_ff2 & ~int_ff3;

    assign rt_new   = {rate_hi, rate_lo} - RATE_OFFSET;
    assign acc_ext  = {{11{acc_hi[7]}}, acc_hi, acc_lo};
    assign prod     = acc_ext * 27'sd327;
    assign ptch_acc = {{4{prod[24]}}, prod[24:13]};

    // Upper response byte and the discarded product bits are intentionally dropped.
    assign unused_bits = &{1'b0, rd_data[15:8], prod[26:25], prod[12:0]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_PWR;
        else        state <= nxt_state;
    end

    // Next-state logic: command states advance only on the SPI done strobe
    always_comb begin
        nxt_state = state;
        case (state)
            WAIT_PWR: if (tmr_full) nxt_state = INIT1;
            INIT1:    if (done)     nxt_state = INIT2;
            INIT2:    if (done)     nxt_state = INIT3;
            INIT3:    if (done)     nxt_state = INIT4;
            INIT4:    if (done)     nxt_state = IDLE;
            IDLE:     if (int_rise) nxt_state = RD_RL;
            RD_RL:    if (done)     nxt_state = RD_RH;
            RD_RH:    if (done)     nxt_state = RD_AL;
            RD_AL:    if (done)     nxt_state = RD_AH;
            RD_AH:    if (done)     nxt_state = CALC;
            CALC:                   nxt_state = IDLE;
            default:                nxt_state = WAIT_PWR;
        endcase
    end

    // Output decode: launch a command on entry to each command state, capture bytes on done
    always_comb begin
        wrt_d  = 1'b0;
        cmd_d  = 16'h0000;
        cap_rl = 1'b0;
        cap_rh = 1'b0;
        cap_al = 1'b0;
        cap_ah = 1'b0;
        calc   = (state == CALC);
        if (nxt_state != state) begin
            case (nxt_state)
                INIT1:   begin wrt_d = 1'b1; cmd_d = 16'h0D02; end
                INIT2:   begin wrt_d = 1'b1; cmd_d = 16'h1053; end
                INIT3:   begin wrt_d = 1'b1; cmd_d = 16'h1150; end
                INIT4:   begin wrt_d = 1'b1; cmd_d = 16'h1460; end
                RD_RL:   begin wrt_d = 1'b1; cmd_d = 16'hA200; end
                RD_RH:   begin wrt_d = 1'b1; cmd_d = 16'hA300; end
                RD_AL:   begin wrt_d = 1'b1; cmd_d = 16'hAA00; end
                RD_AH:   begin wrt_d = 1'b1; cmd_d = 16'hAB00; end
                default: begin wrt_d = 1'b0; cmd_d = 16'h0000; end
            endcase
        end
        if (done) begin
            case (state)
                RD_RL:   cap_rl = 1'b1;
                RD_RH:   cap_rh = 1'b1;
                RD_AL:   cap_al = 1'b1;
                RD_AH:   cap_ah = 1'b1;
                default: ;
            endcase
        end
    end

    // Power-up timer, only advances while waiting for the IMU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                tmr <= 16'h0000;
        else if (state == WAIT_PWR) tmr <= tmr + 16'h0001;
    end

    // INT synchronizer plus edge-detect flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
            int_ff3 <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
            int_ff3 <= int_ff2;
        end
    end

    // Registered SPI command strobe; cmd holds until the next launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrt <= 1'b0;
            cmd <= 16'h0000;
        end else begin
            wrt <= wrt_d;
            if (wrt_d) cmd <= cmd_d;
        end
    end

    // Response byte capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_lo <= 8'h00;
            rate_hi <= 8'h00;
            acc_lo  <= 8'h00;
            acc_hi  <= 8'h00;
        end else begin
            if (cap_rl) rate_lo <= rd_data[7:0];
            if (cap_rh) rate_hi <= rd_data[7:0];
            if (cap_al) acc_lo  <= rd_data[7:0];
            if (cap_ah) acc_hi  <= rd_data[7:0];
        end
    end

`ifdef INERT_FUSION_EN
    logic signed [26:0] ptch_int, ptch_int_nxt, fuse_step;

    // Pull the integrated estimate toward the accel pitch by a fixed step
    assign fuse_step    = (ptch_acc > $signed(ptch)) ? 27'sd1024 : -27'sd1024;
    assign ptch_int_nxt = ptch_int - {{11{rt_new[15]}}, rt_new} + fuse_step;

    // Fusion accumulator, updated once per sample in CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ptch_int <= 27'sd0;
        else if (calc) ptch_int <= ptch_int_nxt;
    end
`endif

    // Sample outputs: update and strobe together on the cycle after CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld     <= 1'b0;
            ptch    <= 16'h0000;
            ptch_rt <= 16'h0000;
        end else begin
            vld <= calc;
            if (calc) begin
                ptch_rt <= rt_new;
`ifdef INERT_FUSION_EN
                ptch    <= ptch_int_nxt[26:11];
`else
                ptch    <= ptch_acc;
`endif
            end
        end
    end

endmodule
